mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sole owner of the byte-serial RAM/IO port.
- Serves instruction-word reads for the instruction cache (its need_mem / mem_addr / mem_ins / mem_ins_ready handshake) and byte/half/word loads and stores for the load-store buffer.
- Assembles little-endian bytes into 32-bit words and splits stores into byte writes.
- Arbitrates between the two requesters. A flush aborts an in-flight instruction fetch.

Parameters:
IO_HI, 2'b11, value of address bits [17:16] that marks an IO address
ADDR_W, 32, address width

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  pause; controller frozen when low
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  UART buffer full; IO writes must stall
clear  in  1  flush (mispredict); aborts instruction fetch
if_req  in  1  instruction read request (held until if_ready)
if_addr  in  32  instruction address, word-aligned
if_data  out  32  fetched word
if_ready  out  1  one-cycle pulse, if_data valid
ls_req  in  1  load/store request (held until ls_ready)
ls_we  in  1  1 = store
ls_addr  in  32  data address
ls_size  in  2  0 = byte, 1 = half, 2 = word
ls_wdata  in  32  store data, low bytes used
ls_rdata  out  32  load data, zero-extended
ls_ready  out  1  one-cycle pulse, load data valid or store done

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; counter 0; mem_a=0; mem_dout=0; mem_wr=0; if_data=0; ls_rdata=0; if_ready=0; ls_ready=0. A reset mid-transaction abandons it with no further RAM writes.
- rdy_in low:
  - No register changes; mem_wr driven 0.
  - A read byte is sampled only in a cycle with rdy_in high whose preceding cycle issued that byte's address with rdy_in high. Otherwise the address is re-issued.
- States: IDLE, IF_RD, LS_RD, LS_WR. Counter cnt is 3 bits. Byte count N = 1, 2 or 4 from ls_size; if reads are always N=4.
- IDLE arbitration:
  - Each cycle, if_ready and ls_ready are 0 unless set that cycle.
  - ls_req has priority over if_req.
  - Requests are ignored in any cycle where if_ready or ls_ready is high. Requesters drop req one edge after the ready pulse, so this prevents a duplicate start.
  - if_req is ignored while clear is high.
- Read (IF_RD / LS_RD):
  - Start cycle C: mem_a = addr, mem_wr = 0.
  - Cycle C+k: mem_a = addr+k for k < N.
  - Byte k is sampled from mem_din in cycle C+k+1 into bits [8k+7:8k].
  - After the last byte, the data register and ready are set. Ready is high in cycle C+N+1, giving word C+5, half C+3, byte C+2.
  - Unused high bits of ls_rdata are 0.
- Write (LS_WR):
  - Cycle C+k: mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - ls_ready is high in cycle C+N.
  - If addr[17:16]==IO_HI and io_buffer_full is high, the byte is not issued (mem_wr = 0) and the cycle repeats until io_buffer_full is low.
- Outside write cycles, mem_wr = 0 and mem_a holds its last value.
- clear:
  - In IF_RD: the transaction aborts next edge to IDLE, if_ready is not asserted, and if_data is unchanged.
  - Coinciding with the IF_RD completion edge: if_ready is suppressed.
  - LS_RD / LS_WR are not affected by clear.
- Misaligned ls_addr: serviced byte-wise as above, no exception.
- Address arithmetic wraps modulo 2^32.

Test Plan:
- Fetch 0x1000, RAM[0x1000..3] = 13 05 00 00, ls_req=0 -> mem_a 0x1000..0x1003 in cycles C..C+3; if_ready one pulse at C+5; if_data = 0x00000513; no restart the cycle after.
- if_req and ls_req (load word 0x2000) asserted the same cycle -> load serviced first, ls_ready at C+5; fetch then starts, with its first mem_a after ls_ready.
- Store half 0xBEEF to 0x2002 -> mem_wr=1 in two cycles, (0x2002, EF) then (0x2003, BE); ls_ready at C+2; load byte 0x2003 returns ls_rdata = 0x000000BE.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those cycles; single write (0x30000, 0x41) after release; exactly one ls_ready.
- clear at cycle C+2 of a fetch -> no if_ready, state IDLE next cycle; a new if_req for 0x1004 then completes normally with 0x1004 data.
- rdy_in low for 2 cycles in the middle of a word load, then rst_in pulsed low mid-store -> load data correct and ready delayed by 2 cycles; after reset all outputs are 0 and no further mem_wr.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Signal bundle between mem_ctrl, the byte-serial RAM/IO port and its two requesters.
// slave is the controller's view; master is the view of the RAM and requesters around it.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;
   logic              clear;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_data;
   logic              if_ready;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [1:0]        ls_size;
   logic [31:0]       ls_wdata;
   logic [31:0]       ls_rdata;
   logic              ls_ready;

   modport slave (
      input  mem_din, io_buffer_full, clear, if_req, if_addr,
             ls_req, ls_we, ls_addr, ls_size, ls_wdata,
      output mem_dout, mem_a, mem_wr, if_data, if_ready, ls_rdata, ls_ready
   );

   modport master (
      output mem_din, io_buffer_full, clear, if_req, if_addr,
             ls_req, ls_we, ls_addr, ls_size, ls_wdata,
      input  mem_dout, mem_a, mem_wr, if_data, if_ready, ls_rdata, ls_ready
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port owner: assembles little-endian instruction/data words from
// byte reads, splits stores into byte writes, and arbitrates load-store over fetch.
module mem_ctrl #(
   parameter logic [1:0] IO_HI  = 2'b11,
   parameter int         ADDR_W = 32
) (
   input  logic      clk_in,
   input  logic      rst_in,
   input  logic      rdy_in,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

   state_t            state_q;
   logic [2:0]        cnt_q;
   logic [2:0]        idx_q;
   logic [2:0]        nbytes_q;
   logic              iss_q;
   logic              rdy_prev_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic [7:0]        mem_dout_q;
   logic              mem_wr_q;
   logic [31:0]       buf_q;
   logic [31:0]       wdata_q;
   logic [31:0]       if_data_q;
   logic [31:0]       ls_rdata_q;
   logic              if_ready_q;
   logic              ls_ready_q;

   logic              got_d;
   logic              done_d;
   logic              io_blk_d;
   logic [2:0]        cnt_d;
   logic [31:0]       buf_d;

   function automatic logic [2:0] n_of(input logic [1:0] size);
      case (size)
         2'd0:    n_of = 3'd1;
         2'd1:    n_of = 3'd2;
         default: n_of = 3'd4;
      endcase
   endfunction

   // mem_din carries byte cnt_q only if the previous cycle issued exactly that byte with rdy high
   always_comb begin
      got_d    = (state_q == IF_RD || state_q == LS_RD) && iss_q && rdy_prev_q;
      buf_d    = buf_q;
      if (got_d) buf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
      cnt_d    = got_d ? cnt_q + 3'd1 : cnt_q;
      done_d   = got_d && (cnt_d == nbytes_q);
      io_blk_d = (mem_a_q[17:16] == IO_HI) && bus.io_buffer_full;
   end

   assign bus.mem_wr   = mem_wr_q && rdy_in && !io_blk_d;
   assign bus.mem_a    = mem_a_q;
   assign bus.mem_dout = mem_dout_q;
   assign bus.if_data  = if_data_q;
   assign bus.if_ready = if_ready_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.ls_ready = ls_ready_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         nbytes_q   <= '0;
         iss_q      <= 1'b0;
         rdy_prev_q <= 1'b0;
         base_q     <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         buf_q      <= '0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
         if_ready_q <= 1'b0;
         ls_ready_q <= 1'b0;
      end else if (!rdy_in) begin
         rdy_prev_q <= 1'b0;
      end else begin
         rdy_prev_q <= 1'b1;
         if_ready_q <= 1'b0;
         ls_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // the cycle carrying a ready pulse still sees the old request, so skip it
               if (!if_ready_q && !ls_ready_q) begin
                  if (bus.ls_req) begin
                     base_q   <= bus.ls_addr;
                     mem_a_q  <= bus.ls_addr;
                     cnt_q    <= '0;
                     idx_q    <= '0;
                     iss_q    <= 1'b0;
                     buf_q    <= '0;
                     nbytes_q <= n_of(bus.ls_size);
                     if (bus.ls_we) begin
                        state_q    <= LS_WR;
                        wdata_q    <= bus.ls_wdata;
                        mem_dout_q <= bus.ls_wdata[7:0];
                        mem_wr_q   <= 1'b1;
                     end else begin
                        state_q <= LS_RD;
                     end
                  end else if (bus.if_req && !bus.clear) begin
                     state_q  <= IF_RD;
                     base_q   <= bus.if_addr;
                     mem_a_q  <= bus.if_addr;
                     cnt_q    <= '0;
                     idx_q    <= '0;
                     iss_q    <= 1'b0;
                     buf_q    <= '0;
                     nbytes_q <= 3'd4;
                  end
               end
            end
            IF_RD, LS_RD: begin
               buf_q <= buf_d;
               cnt_q <= cnt_d;
               if (state_q == IF_RD && bus.clear) begin
                  state_q <= IDLE;
               end else if (done_d) begin
                  state_q <= IDLE;
                  if (state_q == IF_RD) begin
                     if_data_q  <= buf_d;
                     if_ready_q <= 1'b1;
                  end else begin
                     ls_rdata_q <= buf_d;
                     ls_ready_q <= 1'b1;
                  end
               end else if (idx_q == cnt_d) begin
                  iss_q <= 1'b1;
                  if (idx_q + 3'd1 != nbytes_q) begin
                     idx_q   <= idx_q + 3'd1;
                     mem_a_q <= mem_a_q + ADDR_W'(1);
                  end
               end else begin
                  // a byte was lost to a pause: step the address back to the first missing one
                  iss_q   <= 1'b0;
                  idx_q   <= cnt_d;
                  mem_a_q <= base_q + ADDR_W'(cnt_d);
               end
            end
            LS_WR: begin
               if (!io_blk_d) begin
                  if (cnt_q + 3'd1 == nbytes_q) begin
                     state_q    <= IDLE;
                     mem_wr_q   <= 1'b0;
                     ls_ready_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + 3'd1;
                     mem_a_q    <= mem_a_q + ADDR_W'(1);
                     mem_dout_q <= wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, fetch/load/store sequences,
// arbitration, IO back-pressure, flush, pause and reset.
module tb_mem_ctrl;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b1;

   mem_ctrl_if bus();

   mem_ctrl #(.IO_HI(2'b11), .ADDR_W(32)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0]  ram [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_a  = '0;
   logic [7:0]  pl_d  = '0;

   // synchronous byte RAM: data for the address seen at an edge appears after that edge
   always @(posedge clk_in) begin
      bus.mem_din <= ram[bus.mem_a[15:0]];
      if (pl_en) ram[pl_a] <= pl_d;
      else if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      @(negedge clk_in);
      pl_en = 1'b0;
   endtask

   int          rdy_if_c, rdy_ls_c, n_if, n_ls, n_wr;
   logic [31:0] a_log [0:19];
   logic [7:0]  d_log [0:19];
   logic        w_log [0:19];

   // k = 0 is the first cycle after the request is accepted
   task automatic watch(input int ncyc, input int clr_at, input int gap_at,
                        input int gap_len, input int io_len);
      bit drop_if, drop_ls;
      drop_if  = 1'b0;
      drop_ls  = 1'b0;
      rdy_if_c = -1;
      rdy_ls_c = -1;
      n_if = 0; n_ls = 0; n_wr = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk_in);
         if (drop_if) begin bus.if_req = 1'b0; drop_if = 1'b0; end
         if (drop_ls) begin bus.ls_req = 1'b0; drop_ls = 1'b0; end
         bus.clear = (k == clr_at);
         if (k == clr_at) bus.if_req = 1'b0;
         rdy_in = !(k >= gap_at && k < gap_at + gap_len);
         bus.io_buffer_full = (k < io_len);
         #1;
         a_log[k] = bus.mem_a;
         d_log[k] = bus.mem_dout;
         w_log[k] = bus.mem_wr;
         if (bus.mem_wr) n_wr++;
         if (bus.if_ready) begin
            n_if++; drop_if = 1'b1;
            if (rdy_if_c < 0) rdy_if_c = k;
         end
         if (bus.ls_ready) begin
            n_ls++; drop_ls = 1'b1;
            if (rdy_ls_c < 0) rdy_ls_c = k;
         end
      end
   endtask

   task automatic req_if(input logic [31:0] a);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
   endtask

   task automatic req_ls(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic [31:0] wd);
      bus.ls_req   = 1'b1;
      bus.ls_addr  = a;
      bus.ls_we    = we;
      bus.ls_size  = sz;
      bus.ls_wdata = wd;
   endtask

   task automatic chk_zero_outputs(input string pfx);
      chk({pfx, "_mem_a"},    bus.mem_a, 32'h0);
      chk({pfx, "_mem_dout"}, {24'h0, bus.mem_dout}, 32'h0);
      chk({pfx, "_mem_wr"},   {31'h0, bus.mem_wr}, 32'h0);
      chk({pfx, "_if_data"},  bus.if_data, 32'h0);
      chk({pfx, "_ls_rdata"}, bus.ls_rdata, 32'h0);
      chk({pfx, "_if_ready"}, {31'h0, bus.if_ready}, 32'h0);
      chk({pfx, "_ls_ready"}, {31'h0, bus.ls_ready}, 32'h0);
   endtask

   initial begin
      bus.io_buffer_full = 1'b0;
      bus.clear    = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = '0;
      bus.ls_size  = '0;
      bus.ls_wdata = '0;

      // preload while held in reset
      poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
      poke(16'h1004, 8'h93); poke(16'h1005, 8'h00); poke(16'h1006, 8'h10); poke(16'h1007, 8'h00);
      poke(16'h2000, 8'h78); poke(16'h2001, 8'h56); poke(16'h2002, 8'h34); poke(16'h2003, 8'h12);
      chk_zero_outputs("reset");
      rst_in = 1'b1;
      @(negedge clk_in);
      #1;

      // instruction fetch of 0x1000
      req_if(32'h1000);
      watch(8, -1, -1, 0, 0);
      for (int k = 0; k < 4; k++) chk("fetch_addr", a_log[k], 32'h1000 + 32'(k));
      chk("fetch_rdy_cycle", rdy_if_c, 32'd5);
      chk("fetch_rdy_count", n_if, 32'd1);
      chk("fetch_data", bus.if_data, 32'h0000_0513);
      chk("fetch_no_restart6", a_log[6], 32'h1003);
      chk("fetch_no_restart7", a_log[7], 32'h1003);

      // simultaneous requests: load word 0x2000 wins, then the fetch
      req_if(32'h1000);
      req_ls(32'h2000, 1'b0, 2'd2, 32'h0);
      watch(15, -1, -1, 0, 0);
      chk("arb_ls_rdy_cycle", rdy_ls_c, 32'd5);
      chk("arb_ls_data", bus.ls_rdata, 32'h1234_5678);
      chk("arb_if_not_early", a_log[6], 32'h2003);
      chk("arb_if_first_addr", a_log[7], 32'h1000);
      chk("arb_if_rdy_cycle", rdy_if_c, 32'd12);
      chk("arb_if_data", bus.if_data, 32'h0000_0513);

      // store half 0xBEEF to 0x2002
      req_ls(32'h2002, 1'b1, 2'd1, 32'h0000_BEEF);
      watch(5, -1, -1, 0, 0);
      chk("sth_wr0", {w_log[0], a_log[0][15:0], d_log[0]}, {1'b1, 16'h2002, 8'hEF});
      chk("sth_wr1", {w_log[1], a_log[1][15:0], d_log[1]}, {1'b1, 16'h2003, 8'hBE});
      chk("sth_wr_count", n_wr, 32'd2);
      chk("sth_rdy_cycle", rdy_ls_c, 32'd2);

      // load byte 0x2003
      req_ls(32'h2003, 1'b0, 2'd0, 32'h0);
      watch(5, -1, -1, 0, 0);
      chk("lb_rdy_cycle", rdy_ls_c, 32'd2);
      chk("lb_data", bus.ls_rdata, 32'h0000_00BE);

      // IO store byte with 3 cycles of buffer-full back-pressure
      req_ls(32'h0003_0000, 1'b1, 2'd0, 32'h0000_0041);
      watch(7, -1, -1, 0, 3);
      chk("io_stall_wr", {29'h0, w_log[0], w_log[1], w_log[2]}, 32'h0);
      chk("io_wr", {w_log[3], a_log[3], d_log[3]}, {1'b1, 32'h0003_0000, 8'h41});
      chk("io_wr_count", n_wr, 32'd1);
      chk("io_rdy_count", n_ls, 32'd1);
      chk("io_rdy_cycle", rdy_ls_c, 32'd4);

      // flush at C+2 of a fetch, then a clean fetch of 0x1004
      req_if(32'h1000);
      watch(6, 2, -1, 0, 0);
      chk("clr_no_ready", n_if, 32'd0);
      chk("clr_addr_frozen", a_log[3], 32'h1002);
      chk("clr_data_kept", bus.if_data, 32'h0000_0513);
      req_if(32'h1004);
      watch(8, -1, -1, 0, 0);
      chk("clr_refetch_rdy", rdy_if_c, 32'd5);
      chk("clr_refetch_data", bus.if_data, 32'h0010_0093);

      // pause for two cycles at the start of a word load
      req_ls(32'h2000, 1'b0, 2'd2, 32'h0);
      watch(10, -1, 0, 2, 0);
      chk("pause_rdy_cycle", rdy_ls_c, 32'd7);
      chk("pause_data", bus.ls_rdata, 32'hBEEF_5678);

      // pause after bytes have been issued: lost byte must be fetched again
      req_ls(32'h2000, 1'b0, 2'd2, 32'h0);
      watch(14, -1, 2, 2, 0);
      chk("pause_mid_count", n_ls, 32'd1);
      chk("pause_mid_data", bus.ls_rdata, 32'hBEEF_5678);

      // reset in the middle of a word store
      req_ls(32'h2000, 1'b1, 2'd2, 32'hCAFE_F00D);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      bus.ls_req = 1'b0;
      bus.ls_we  = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      @(negedge clk_in);
      rst_in = 1'b1;
      watch(4, -1, -1, 0, 0);
      chk("midrst_no_wr", n_wr, 32'd0);
      chk("midrst_no_rdy", n_ls, 32'd0);
      chk("midrst_first_byte", {24'h0, ram[16'h2000]}, 32'h0000_000D);
      chk("midrst_byte1_kept", {24'h0, ram[16'h2001]}, 32'h0000_0056);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
